param_deserializer: RTL and testbench
=====================================

Name: param_deserializer

Overview:
- Parametrised serial-to-parallel converter with sync-word word alignment and bit-order selection.
- Replaces the fixed 16-bit deserializer in the SerDes receive path. Sits between the line-side serial bit stream and the parallel receive datapath.
- Hunts for a programmable sync word to find word boundaries, then emits aligned DATA_W-bit words.
- Output uses a valid/ready handshake with a one-word holding register and a sticky overflow flag.

Parameters:
- DATA_W, 16, parallel word width in bits; legal range 4..64.
- LSB_FIRST, 0, 0 = first serial bit of a word lands in bit DATA_W-1; 1 = first serial bit lands in bit 0.
- SYNC_WORD, 16'hBC5A, alignment pattern, DATA_W bits wide, compared in output bit order.
- DROP_SYNC, 1, 1 = sync words received while locked are not emitted; 0 = they are emitted as data.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- sdata  input  1  serial data bit, sampled on the clk rising edge only when bit_en=1
- bit_en  input  1  qualifies sdata; when 0, no shift and no count
- resync  input  1  synchronous request to drop lock and re-hunt
- clr_ovf  input  1  synchronous clear of overflow
- out_data  output  DATA_W  aligned parallel word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream accepts the word when out_valid&&out_ready
- locked  output  1  word alignment established
- is_sync  output  1  qualifies out_data as a sync word (only possible with DROP_SYNC=0)
- overflow  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (reset_n low, asynchronous):
  - shift register = 0, bit_cnt = 0, state = HUNT.
  - out_data = 0, out_valid = 0, is_sync = 0, locked = 0, overflow = 0.
- Shift, on each clk edge with bit_en=1:
  - LSB_FIRST=0: shreg <= {shreg[DATA_W-2:0], sdata}.
  - LSB_FIRST=1: shreg <= {sdata, shreg[DATA_W-1:1]}.
  - nxt denotes the post-shift value.
- State HUNT:
  - Each bit_en cycle, compare nxt against SYNC_WORD.
  - On a match: go to LOCKED, bit_cnt <= 0, locked=1 from the next cycle.
  - The matching sync word itself is never emitted.
- State LOCKED:
  - bit_cnt increments on each bit_en and wraps DATA_W-1 -> 0.
  - A word completes on a bit_en cycle with bit_cnt == DATA_W-1; the word is nxt.
  - Completed word equal to SYNC_WORD with DROP_SYNC=1: discarded, no other effect.
  - Otherwise the word is offered to the output stage.
- resync=1 (any state): next state HUNT, bit_cnt <= 0, locked <= 0.
  - The shift register keeps shifting if bit_en=1.
  - A word completing in the same cycle is discarded.
  - out_valid, out_data and the holding register are unaffected.
- Output stage (single holding register):
  - Consume = out_valid && out_ready.
  - Offer with out_valid=0, or with consume in the same cycle: out_data <= word, is_sync <= (word==SYNC_WORD), out_valid <= 1.
  - Offer with out_valid=1 and out_ready=0: word dropped, out_data keeps its old value, overflow <= 1.
  - Consume with no offer: out_valid <= 0; out_data is held.
  - out_data and is_sync are stable while out_valid && !out_ready.
- Latency: out_valid rises on the clk edge that samples the last bit of a word, i.e. visible 1 cycle after that bit is presented.
- overflow: set by a drop, cleared by clr_ovf. A drop and clr_ovf in the same cycle leaves overflow = 1.
- bit_en=0: no shift, no count, no word completion. The handshake still progresses.
- Throughput: at most 1 word per DATA_W bit_en cycles. out_ready held high never overflows.

Test Plan:
- Sync then data, DATA_W=16, LSB_FIRST=0, bit_en=1, out_ready=1: send serial 0xBC5A then 0x1234 MSB-first -> locked=1 after the 16th bit. 16 cycles later out_valid=1 for 1 cycle with out_data=0x1234 and is_sync=0. No word emitted for 0xBC5A.
- Misaligned start: send 5 junk bits, then 0xBC5A, 0xCAFE, 0xBC5A, 0x0001 -> outputs are exactly 0xCAFE then 0x0001 (mid sync dropped with DROP_SYNC=1). locked stays 1 throughout.
- LSB_FIRST=1: send the bits of 0xBC5A then 0x00F1, each bit-0-first -> locked=1 and out_data=0x00F1.
- Backpressure: out_ready=0 while 0x1111 then 0x2222 complete -> out_data stays 0x1111, overflow=1. Raise out_ready -> one transfer of 0x1111. Pulse clr_ovf -> overflow=0.
- bit_en gaps and resync: toggle bit_en 1/0 during a word -> the same word is produced with doubled latency. Assert resync mid-word -> locked=0 next cycle, no word emitted until a new 0xBC5A is received.
- Async reset mid-word with out_valid=1 -> all outputs 0 immediately. After release, no word is emitted until a sync word is received.

Source files
------------

// File: rtl/param_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : param_deserializer
// Brief    : Parametrised serial-to-parallel converter. Hunts for a sync word
//            to establish word alignment, then emits aligned DATA_W-bit words
//            through a one-word valid/ready holding register with a sticky
//            overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module param_deserializer #(
  parameter int                 DATA_W    = 16,
  parameter bit                 LSB_FIRST = 1'b0,
  parameter logic [DATA_W-1:0]  SYNC_WORD = DATA_W'(16'hBC5A),
  parameter bit                 DROP_SYNC = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdata,
  input  logic              bit_en,
  input  logic              resync,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              is_sync,
  output logic              overflow
);

  localparam int                c_CNT_W = $clog2(DATA_W);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic [c_CNT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_nxt;
  logic                w_word_done;
  logic                w_is_sync_word;
  logic                w_offer;
  logic                w_consume;
  logic                w_drop;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_is_sync;
  logic                r_overflow;

  // Bit order only changes which end of the shift register the new bit enters.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shifted = {sdata, r_shreg[DATA_W-1:1]};
    end else begin : g_msb_first
      assign w_shifted = {r_shreg[DATA_W-2:0], sdata};
    end
  endgenerate

  assign w_nxt          = bit_en ? w_shifted : r_shreg;
  assign w_is_sync_word = (w_nxt == SYNC_WORD);
  assign w_offer        = w_word_done && !(DROP_SYNC && w_is_sync_word);
  assign w_consume      = r_out_valid && out_ready;
  assign w_drop         = w_offer && r_out_valid && !out_ready;

  // Serial shift register, advanced only on qualified bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
    end else if (bit_en) begin
      r_shreg <= w_shifted;
    end
  end

  // Alignment state and bit counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_HUNT;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state: resync overrides everything and discards a word completing now.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_word_done   = 1'b0;
    if (resync) begin
      w_state_nxt   = S_HUNT;
      w_bit_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_HUNT: begin
          if (bit_en && w_is_sync_word) begin
            w_state_nxt   = S_LOCKED;
            w_bit_cnt_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (bit_en) begin
            if (r_bit_cnt == c_LAST) begin
              w_bit_cnt_nxt = '0;
              w_word_done   = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt   = S_HUNT;
          w_bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Holding register: load when empty or being drained, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_is_sync   <= 1'b0;
    end else if (w_offer && (!r_out_valid || out_ready)) begin
      r_out_data  <= w_nxt;
      r_out_valid <= 1'b1;
      r_is_sync   <= w_is_sync_word;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign is_sync   = r_is_sync;
  assign overflow  = r_overflow;
  assign locked    = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_param_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_deserializer
// Brief    : Self-checking bench for param_deserializer. Three instances share
//            one stimulus stream: MSB-first/drop-sync, LSB-first/drop-sync and
//            MSB-first/keep-sync. Each is compared every cycle to a bit-list
//            reference model, plus directed checks on captured transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_deserializer;

  localparam logic [15:0] c_SYNC = 16'hBC5A;

  logic        clk;
  logic        reset_n;
  logic        sdata, bit_en, resync, clr_ovf, out_ready;
  logic [15:0] od [3];
  logic        ov [3];
  logic        lk [3];
  logic        is [3];
  logic        of [3];

  bit c_lsb  [3] = '{1'b0, 1'b1, 1'b0};
  bit c_drop [3] = '{1'b1, 1'b1, 1'b0};

  int n_checks = 0;
  int n_errors = 0;

  param_deserializer #(.DATA_W(16), .LSB_FIRST(1'b0), .SYNC_WORD(16'hBC5A), .DROP_SYNC(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .sdata(sdata), .bit_en(bit_en), .resync(resync),
    .clr_ovf(clr_ovf), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .locked(lk[0]), .is_sync(is[0]), .overflow(of[0]));

  param_deserializer #(.DATA_W(16), .LSB_FIRST(1'b1), .SYNC_WORD(16'hBC5A), .DROP_SYNC(1'b1)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .sdata(sdata), .bit_en(bit_en), .resync(resync),
    .clr_ovf(clr_ovf), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .locked(lk[1]), .is_sync(is[1]), .overflow(of[1]));

  param_deserializer #(.DATA_W(16), .LSB_FIRST(1'b0), .SYNC_WORD(16'hBC5A), .DROP_SYNC(1'b0)) dut_keep (
    .clk(clk), .reset_n(reset_n), .sdata(sdata), .bit_en(bit_en), .resync(resync),
    .clr_ovf(clr_ovf), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .locked(lk[2]), .is_sync(is[2]), .overflow(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: recent-bit history for hunting, list of bits since lock.
  bit          m_hist   [3][16];
  bit          m_wb     [3][16];
  int          m_wn     [3];
  bit          m_locked [3];
  bit          m_valid  [3];
  logic [15:0] m_data   [3];
  bit          m_sync   [3];
  bit          m_ovf    [3];

  logic [15:0] got0 [$];
  logic [15:0] got1 [$];
  logic [15:0] got2 [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First received bit is b[0]; it lands in bit 15 (MSB-first) or bit 0.
  function automatic logic [15:0] pack_bits(input bit b [16], input bit lsb);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (lsb) p[i] = b[i];
      else     p[15-i] = b[i];
    end
    return p;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_hist[k][i] = 1'b0;
        m_wb[k][i]   = 1'b0;
      end
      m_wn[k] = 0; m_locked[k] = 1'b0; m_valid[k] = 1'b0;
      m_data[k] = '0; m_sync[k] = 1'b0; m_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k, input bit sd, input bit be,
                                     input bit rs, input bit co, input bit rdy);
    bit          consume;
    bit          offer;
    bit          dropped;
    logic [15:0] word;
    bit          tmp [16];
    consume = m_valid[k] && rdy;
    offer   = 1'b0;
    dropped = 1'b0;
    word    = '0;
    if (be) begin
      for (int i = 0; i < 15; i++) m_hist[k][i] = m_hist[k][i+1];
      m_hist[k][15] = sd;
    end
    if (rs) begin
      m_locked[k] = 1'b0;
      m_wn[k]     = 0;
    end else if (!m_locked[k]) begin
      if (be) begin
        for (int i = 0; i < 16; i++) tmp[i] = m_hist[k][i];
        if (pack_bits(tmp, c_lsb[k]) == c_SYNC) begin
          m_locked[k] = 1'b1;
          m_wn[k]     = 0;
        end
      end
    end else if (be) begin
      m_wb[k][m_wn[k]] = sd;
      m_wn[k]++;
      if (m_wn[k] == 16) begin
        for (int i = 0; i < 16; i++) tmp[i] = m_wb[k][i];
        word    = pack_bits(tmp, c_lsb[k]);
        m_wn[k] = 0;
        offer   = !(c_drop[k] && word == c_SYNC);
      end
    end
    if (offer) begin
      if (!m_valid[k] || rdy) begin
        m_data[k]  = word;
        m_sync[k]  = (word == c_SYNC);
        m_valid[k] = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (consume) begin
      m_valid[k] = 1'b0;
    end
    if (dropped)  m_ovf[k] = 1'b1;
    else if (co)  m_ovf[k] = 1'b0;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(m_valid[k]));
      check($sformatf("out_data[%0d]", k),  64'(od[k]), 64'(m_data[k]));
      check($sformatf("locked[%0d]", k),    64'(lk[k]), 64'(m_locked[k]));
      check($sformatf("is_sync[%0d]", k),   64'(is[k]), 64'(m_sync[k]));
      check($sformatf("overflow[%0d]", k),  64'(of[k]), 64'(m_ovf[k]));
    end
  endtask

  // One clock: drive inputs, log transfers, advance model at the edge, compare.
  task automatic cycle(input bit sd, input bit be, input bit rs, input bit co, input bit rdy);
    sdata = sd; bit_en = be; resync = rs; clr_ovf = co; out_ready = rdy;
    if (ov[0] && rdy) got0.push_back(od[0]);
    if (ov[1] && rdy) got1.push_back(od[1]);
    if (ov[2] && rdy) got2.push_back(od[2]);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, sd, be, rs, co, rdy);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [15:0] w, input bit lsb, input bit rdy);
    for (int i = 0; i < 16; i++) cycle(lsb ? w[i] : w[15-i], 1'b1, 1'b0, 1'b0, rdy);
  endtask

  int   n_before;
  bit   pend [$];
  logic [15:0] rw;
  bit   rlsb;
  bit   junk [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    reset_n = 1'b0; sdata = 1'b0; bit_en = 1'b0; resync = 1'b0;
    clr_ovf = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Sync then data, MSB first.
    send_word(c_SYNC, 1'b0, 1'b1);
    check("lock_after_sync", 64'(lk[0]), 64'd1);
    send_word(16'h1234, 1'b0, 1'b1);
    check("valid_after_data", 64'(ov[0]), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("first_word_count", 64'(got0.size()), 64'd1);
    check("first_word", 64'(got0[0]), 64'h1234);

    // Misaligned start: junk, sync, data, mid-stream sync, data.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(junk[i], 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(c_SYNC, 1'b0, 1'b1);
    send_word(16'hCAFE, 1'b0, 1'b1);
    send_word(c_SYNC, 1'b0, 1'b1);
    send_word(16'h0001, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("misalign_count", 64'(got0.size()), 64'd3);
    check("misalign_w1", 64'(got0[1]), 64'hCAFE);
    check("misalign_w2", 64'(got0[2]), 64'h0001);
    check("keep_count", 64'(got2.size()), 64'd4);
    check("keep_sync_word", 64'(got2[2]), 64'(c_SYNC));

    // LSB-first instance.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(c_SYNC, 1'b1, 1'b1);
    check("lsb_lock", 64'(lk[1]), 64'd1);
    send_word(16'h00F1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lsb_word", 64'(got1[got1.size()-1]), 64'h00F1);

    // Backpressure and overflow.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(c_SYNC, 1'b0, 1'b1);
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    check("bp_data_held", 64'(od[0]), 64'h1111);
    check("bp_overflow", 64'(of[0]), 64'd1);
    n_before = got0.size();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_one_transfer", 64'(got0.size()), 64'(n_before + 1));
    check("bp_transfer_data", 64'(got0[got0.size()-1]), 64'h1111);
    check("bp_valid_clear", 64'(ov[0]), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_ovf", 64'(of[0]), 64'd0);

    // bit_en gaps: alternate qualified and idle cycles.
    for (int i = 0; i < 16; i++) begin
      rw = 16'hABCD;
      cycle(rw[15-i], 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("gap_word", 64'(got0[got0.size()-1]), 64'hABCD);

    // Resync mid-word: nothing until a fresh sync word.
    rw = 16'h9876;
    for (int i = 0; i < 8; i++) cycle(rw[15-i], 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(rw[7], 1'b1, 1'b1, 1'b0, 1'b1);
    check("resync_unlock", 64'(lk[0]), 64'd0);
    n_before = got0.size();
    for (int i = 9; i < 16; i++) cycle(rw[15-i], 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(16'h5555, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("resync_no_word", 64'(got0.size()), 64'(n_before));
    send_word(c_SYNC, 1'b0, 1'b1);
    send_word(16'h7777, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("relock_word", 64'(got0[got0.size()-1]), 64'h7777);

    // Randomized stream with frequent sync words in either bit order.
    for (int c = 0; c < 2500; c++) begin
      bit be, sd;
      if (pend.size() == 0) begin
        rw   = ($urandom_range(0, 9) < 3) ? c_SYNC : 16'($urandom);
        rlsb = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) pend.push_back(rlsb ? rw[i] : rw[15-i]);
      end
      be = ($urandom_range(0, 3) != 0);
      sd = be ? pend.pop_front() : 1'($urandom);
      cycle(sd, be, ($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-word while a word is held.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(c_SYNC, 1'b0, 1'b1);
    send_word(16'h3C3C, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_reset_valid", 64'(ov[0]), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_before = got0.size();
    send_word(16'h3C3C, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_no_word", 64'(got0.size()), 64'(n_before));
    send_word(c_SYNC, 1'b0, 1'b1);
    send_word(16'h4242, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_word", 64'(got0[got0.size()-1]), 64'h4242);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
